// File: rtl/wr_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_arb_pkg                                                       |
// | Shared states and AXI encodings for the two-port write arbiter.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package wr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    AWWAIT = 2'd2
  } arb_state_t;

  localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Round-robin pick between two requesters; on a tie the one not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/grant_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grant_fifo                                                       |
// | Small FIFO of granted requester ids awaiting their B response.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module grant_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign full   = r_count[c_aw];
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_aw'(1);
      if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw + 1)'(1);
        2'b01:   r_count <= r_count - (c_aw + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wr_burst_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wr_burst_arbiter                                                 |
// | Two-requester AXI4 write-burst arbiter with B response routing.  |
// | Optional statistics counters enabled by macro WR_ARB_STATS_EN.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wr_burst_arbiter
  import wr_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [127:0]  S_AWADDR,
  input  logic [15:0]   S_AWLEN,
  input  logic [1:0]    S_AWVALID,
  output logic [1:0]    S_AWREADY,
  input  logic [1023:0] S_WDATA,
  input  logic [127:0]  S_WSTRB,
  input  logic [1:0]    S_WLAST,
  input  logic [1:0]    S_WVALID,
  output logic [1:0]    S_WREADY,
  output logic [3:0]    S_BRESP,
  output logic [1:0]    S_BVALID,
  input  logic [1:0]    S_BREADY,
  output logic [63:0]   M_AXI_AWADDR,
  output logic [7:0]    M_AXI_AWLEN,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [2:0]    M_AXI_AWSIZE,
  output logic [1:0]    M_AXI_AWBURST,
  output logic [511:0]  M_AXI_WDATA,
  output logic [63:0]   M_AXI_WSTRB,
  output logic          M_AXI_WLAST,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic          busy
`ifdef WR_ARB_STATS_EN
  ,
  output logic [63:0]   grant_count,
  output logic [31:0]   bresp_err_count
`endif
);

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  logic        r_gnt;
  logic        r_awvalid;
  logic [63:0] r_awaddr;
  logic [7:0]  r_awlen;

  logic        w_pick;
  logic        w_grant;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_fifo_head;

  assign w_pick  = rr_pick(S_AWVALID, r_gnt);
  // Full is registered occupancy, so a same-cycle pop cannot open a grant.
  assign w_grant = (r_state == IDLE) && (|S_AWVALID) && !w_fifo_full;
  assign w_aw_hs = r_awvalid && M_AXI_AWREADY;
  assign w_w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign w_b_hs  = !w_fifo_empty && M_AXI_BVALID && M_AXI_BREADY;

  grant_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_grant_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_grant),
    .din    (w_pick),
    .pop    (w_b_hs),
    .dout   (w_fifo_head),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_state_nxt = XFER;
      XFER:    if (w_w_hs && M_AXI_WLAST)
                 w_state_nxt = (r_awvalid && !M_AXI_AWREADY) ? AWWAIT : IDLE;
      AWWAIT:  if (w_aw_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b1;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt     <= w_pick;
        r_awvalid <= 1'b1;
        r_awaddr  <= w_pick ? S_AWADDR[127:64] : S_AWADDR[63:0];
        r_awlen   <= w_pick ? S_AWLEN[15:8] : S_AWLEN[7:0];
      end else if (w_aw_hs) begin
        r_awvalid <= 1'b0;
      end
    end
  end

  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWSIZE  = AXI_SIZE_64B;
  assign M_AXI_AWBURST = AXI_BURST_INCR;

  // Grant accept is combinational on S_AWVALID, so it is masked while reset is held.
  assign S_AWREADY = (resetn && w_grant) ? (w_pick ? 2'b10 : 2'b01) : 2'b00;

  assign M_AXI_WDATA  = r_gnt ? S_WDATA[1023:512] : S_WDATA[511:0];
  assign M_AXI_WSTRB  = r_gnt ? S_WSTRB[127:64]   : S_WSTRB[63:0];
  assign M_AXI_WLAST  = r_gnt ? S_WLAST[1]        : S_WLAST[0];
  assign M_AXI_WVALID = (r_state == XFER) && (r_gnt ? S_WVALID[1] : S_WVALID[0]);
  assign S_WREADY     = (r_state != XFER) ? 2'b00 :
                        (r_gnt ? {M_AXI_WREADY, 1'b0} : {1'b0, M_AXI_WREADY});

  always_comb begin
    S_BVALID     = 2'b00;
    S_BRESP      = 4'b0000;
    // Responses with nobody waiting are swallowed.
    M_AXI_BREADY = resetn;
    if (!w_fifo_empty) begin
      if (w_fifo_head) begin
        S_BVALID[1]  = M_AXI_BVALID;
        S_BRESP[3:2] = M_AXI_BRESP;
        M_AXI_BREADY = S_BREADY[1];
      end else begin
        S_BVALID[0]  = M_AXI_BVALID;
        S_BRESP[1:0] = M_AXI_BRESP;
        M_AXI_BREADY = S_BREADY[0];
      end
    end
  end

  assign busy = (r_state != IDLE) || !w_fifo_empty;

`ifdef WR_ARB_STATS_EN
  logic [31:0] r_gcnt0;
  logic [31:0] r_gcnt1;
  logic [31:0] r_berr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_gcnt0 <= '0;
      r_gcnt1 <= '0;
      r_berr  <= '0;
    end else begin
      if (w_grant) begin
        if (w_pick) r_gcnt1 <= r_gcnt1 + 32'd1;
        else        r_gcnt0 <= r_gcnt0 + 32'd1;
      end
      if (w_b_hs && (M_AXI_BRESP != RESP_OKAY) && (r_berr != 32'hFFFF_FFFF))
        r_berr <= r_berr + 32'd1;
    end
  end

  assign grant_count     = {r_gcnt1, r_gcnt0};
  assign bresp_err_count = r_berr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_burst_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_wr_burst_arbiter                                              |
// | Directed scoreboard bench for wr_burst_arbiter.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_wr_burst_arbiter;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [127:0]  S_AWADDR = '0;
  logic [15:0]   S_AWLEN = '0;
  logic [1:0]    S_AWVALID = '0;
  logic [1:0]    S_AWREADY;
  logic [1023:0] S_WDATA = '0;
  logic [127:0]  S_WSTRB = '0;
  logic [1:0]    S_WLAST = '0;
  logic [1:0]    S_WVALID = '0;
  logic [1:0]    S_WREADY;
  logic [3:0]    S_BRESP;
  logic [1:0]    S_BVALID;
  logic [1:0]    S_BREADY = 2'b11;
  logic [63:0]   M_AXI_AWADDR;
  logic [7:0]    M_AXI_AWLEN;
  logic          M_AXI_AWVALID;
  logic          M_AXI_AWREADY = 1'b1;
  logic [2:0]    M_AXI_AWSIZE;
  logic [1:0]    M_AXI_AWBURST;
  logic [511:0]  M_AXI_WDATA;
  logic [63:0]   M_AXI_WSTRB;
  logic          M_AXI_WLAST;
  logic          M_AXI_WVALID;
  logic          M_AXI_WREADY = 1'b1;
  logic [1:0]    M_AXI_BRESP = '0;
  logic          M_AXI_BVALID = 1'b0;
  logic          M_AXI_BREADY;
  logic          busy;
`ifdef WR_ARB_STATS_EN
  logic [63:0]   grant_count;
  logic [31:0]   bresp_err_count;
`endif

  wr_burst_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .S_AWADDR      (S_AWADDR),
    .S_AWLEN       (S_AWLEN),
    .S_AWVALID     (S_AWVALID),
    .S_AWREADY     (S_AWREADY),
    .S_WDATA       (S_WDATA),
    .S_WSTRB       (S_WSTRB),
    .S_WLAST       (S_WLAST),
    .S_WVALID      (S_WVALID),
    .S_WREADY      (S_WREADY),
    .S_BRESP       (S_BRESP),
    .S_BVALID      (S_BVALID),
    .S_BREADY      (S_BREADY),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_AWSIZE  (M_AXI_AWSIZE),
    .M_AXI_AWBURST (M_AXI_AWBURST),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .busy          (busy)
`ifdef WR_ARB_STATS_EN
    ,
    .grant_count     (grant_count),
    .bresp_err_count (bresp_err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int grants = 0;

  logic [71:0] aw_q[$];
  int          g_q[$];
  logic [1:0]  r_q[$];
  logic [71:0] e_aw;
  int          e_g;
  logic [1:0]  e_r;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_aw(input int r, input logic [63:0] addr, input logic [7:0] len);
    S_AWADDR[r*64 +: 64] = addr;
    S_AWLEN[r*8 +: 8]    = len;
    S_AWVALID[r]         = 1'b1;
  endtask

  task automatic beats(input int r, input int n, input logic [31:0] base, input bit with_last);
    logic [1:0] ew;
    ew = (r == 0) ? 2'b01 : 2'b10;
    for (int k = 0; k < n; k++) begin
      S_WVALID[r]           = 1'b1;
      S_WLAST[r]            = with_last && (k == n - 1);
      S_WDATA[r*512 +: 32]  = base + 32'(k);
      S_WSTRB[r*64 +: 64]   = '1;
      @(negedge clk);
      chk("w_ready", 64'(S_WREADY), 64'(ew));
      chk("w_valid", 64'(M_AXI_WVALID), 64'd1);
      chk("w_data", 64'(M_AXI_WDATA[31:0]), 64'(base + 32'(k)));
      chk("w_last", 64'(M_AXI_WLAST), 64'(with_last && (k == n - 1)));
      chk("no_grant_in_xfer", 64'(S_AWREADY), 64'd0);
      step();
    end
    if (with_last) begin
      S_WVALID[r] = 1'b0;
      S_WLAST[r]  = 1'b0;
    end
  endtask

  task automatic b_drain(input int n, input logic [1:0] resp);
    M_AXI_BVALID = 1'b1;
    M_AXI_BRESP  = resp;
    for (int k = 0; k < n; k++) begin
      r_q.push_back(resp);
      @(negedge clk);
      step();
    end
    M_AXI_BVALID = 1'b0;
  endtask

  // AW scoreboard: expected address/length pushed at stimulus time.
  always @(negedge clk) begin
    if (resetn && M_AXI_AWVALID && M_AXI_AWREADY) begin
      chk("aw_expected", 64'(aw_q.size() != 0), 64'd1);
      if (aw_q.size() != 0) begin
        e_aw = aw_q.pop_front();
        chk("aw_addr", M_AXI_AWADDR, e_aw[71:8]);
        chk("aw_len", 64'(M_AXI_AWLEN), 64'(e_aw[7:0]));
        chk("aw_size", 64'(M_AXI_AWSIZE), 64'd6);
        chk("aw_burst", 64'(M_AXI_AWBURST), 64'd1);
      end
    end
  end

  // B scoreboard: expected requester order from grants, response from stimulus.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resetn && S_BVALID[i] && S_BREADY[i]) begin
        chk("b_expected", 64'(g_q.size() != 0 && r_q.size() != 0), 64'd1);
        if (g_q.size() != 0 && r_q.size() != 0) begin
          e_g = g_q.pop_front();
          e_r = r_q.pop_front();
          chk("b_route", 64'(i), 64'(e_g));
          chk("b_resp", 64'(S_BRESP[i*2 +: 2]), 64'(e_r));
          chk("b_ready_fwd", 64'(M_AXI_BREADY), 64'd1);
        end
      end
    end
  end

  initial begin
    // Reset state, with both requesters already asking.
    set_aw(0, 64'h1000, 8'd3);
    set_aw(1, 64'h2000, 8'd3);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("rst_awready", 64'(S_AWREADY), 64'd0);
    chk("rst_bready", 64'(M_AXI_BREADY), 64'd0);
    chk("rst_awaddr", M_AXI_AWADDR, 64'd0);
    chk("rst_awlen", 64'(M_AXI_AWLEN), 64'd0);
    step();
    resetn = 1'b1;

    // Simultaneous requests: requester 0 first, then 1.
    aw_q.push_back({64'h1000, 8'd3}); g_q.push_back(0);
    @(negedge clk);
    chk("tie_grant0", 64'(S_AWREADY), 64'h1);
    step();
    S_AWVALID[0] = 1'b0;
    beats(0, 4, 32'hA000, 1'b1);
    aw_q.push_back({64'h2000, 8'd3}); g_q.push_back(1);
    @(negedge clk);
    chk("grant1_after", 64'(S_AWREADY), 64'h2);
    chk("busy_pending", 64'(busy), 64'd1);
    step();
    S_AWVALID[1] = 1'b0;
    beats(1, 4, 32'hB000, 1'b1);

    // OKAY to requester 0, SLVERR to requester 1.
    r_q.push_back(2'd0);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'd0;
    @(negedge clk);
    chk("bvalid_to0", 64'(S_BVALID), 64'h1);
    step();
    r_q.push_back(2'd2);
    M_AXI_BRESP = 2'd2;
    @(negedge clk);
    chk("bvalid_to1", 64'(S_BVALID), 64'h2);
    step();
    M_AXI_BVALID = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
`ifdef WR_ARB_STATS_EN
    chk("stat_berr", 64'(bresp_err_count), 64'd1);
    chk("stat_gcnt", grant_count, {32'd1, 32'd1});
`endif
    step();

    // AW held off for 10 cycles while the W stream runs.
    M_AXI_AWREADY = 1'b0;
    set_aw(0, 64'h3000, 8'd3);
    aw_q.push_back({64'h3000, 8'd3}); g_q.push_back(0);
    @(negedge clk);
    chk("grant_aw_hold", 64'(S_AWREADY), 64'h1);
    step();
    S_AWVALID[0] = 1'b0;
    set_aw(1, 64'h4000, 8'd0);
    beats(0, 4, 32'hC000, 1'b1);
    S_WVALID[0] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("awwait_wvalid", 64'(M_AXI_WVALID), 64'd0);
      chk("awwait_wready", 64'(S_WREADY), 64'd0);
      chk("awwait_nogrant", 64'(S_AWREADY), 64'd0);
      chk("awwait_awvalid", 64'(M_AXI_AWVALID), 64'd1);
      step();
    end
    S_WVALID[0] = 1'b0;
    M_AXI_AWREADY = 1'b1;
    aw_q.push_back({64'h4000, 8'd0}); g_q.push_back(1);
    @(negedge clk);
    chk("awwait_hs_cycle", 64'(S_AWREADY), 64'd0);
    step();
    @(negedge clk);
    chk("idle_after_aw", 64'(S_AWREADY), 64'h2);
    step();
    S_AWVALID[1] = 1'b0;
    beats(1, 1, 32'hD000, 1'b1);
    b_drain(2, 2'd0);

    // Outstanding limit: 6 single-beat commands, B withheld.
    set_aw(0, 64'h5000, 8'd0);
    set_aw(1, 64'h6000, 8'd0);
    S_WVALID = 2'b11; S_WLAST = 2'b11;
    for (int k = 0; k < 5; k++) begin
      aw_q.push_back({((k % 2) == 0) ? 64'h5000 : 64'h6000, 8'd0});
      g_q.push_back(k % 2);
    end
    grants = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (S_AWREADY != 2'b00) grants++;
      step();
    end
    chk("grants_until_full", 64'(grants), 64'd4);
    r_q.push_back(2'd0);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'd0;
    @(negedge clk);
    chk("no_grant_pop_cycle", 64'(S_AWREADY), 64'd0);
    step();
    M_AXI_BVALID = 1'b0;
    @(negedge clk);
    chk("grant_after_pop", 64'(S_AWREADY), 64'h1);
    step();
    S_AWVALID = 2'b00;
    @(negedge clk);
    step();
    S_WVALID = 2'b00; S_WLAST = 2'b00;
    b_drain(4, 2'd0);
    @(negedge clk);
    chk("full_drained", 64'(busy), 64'd0);
    step();

    // Reset in the middle of a 4-beat burst.
    M_AXI_AWREADY = 1'b0;
    set_aw(0, 64'h7000, 8'd3);
    @(negedge clk);
    chk("grant_pre_rst", 64'(S_AWREADY), 64'h1);
    step();
    S_AWVALID[0] = 1'b0;
    beats(0, 2, 32'hE000, 1'b0);
    S_WVALID[0] = 1'b1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    chk("mid_rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    chk("mid_rst_wready", 64'(S_WREADY), 64'd0);
    chk("mid_rst_bvalid", 64'(S_BVALID), 64'd0);
    chk("mid_rst_bready", 64'(M_AXI_BREADY), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_awaddr", M_AXI_AWADDR, 64'd0);
    step();
    resetn = 1'b1;
    S_WVALID[0] = 1'b0;
    M_AXI_AWREADY = 1'b1;
    set_aw(1, 64'h8000, 8'd255);
    aw_q.push_back({64'h8000, 8'd255}); g_q.push_back(1);
    @(negedge clk);
    chk("grant_post_rst", 64'(S_AWREADY), 64'h2);
    step();
    S_AWVALID[1] = 1'b0;
    beats(1, 1, 32'hF000, 1'b1);
    b_drain(1, 2'd3);

    // Spurious B with nothing outstanding.
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'd2;
    @(negedge clk);
    chk("spur_bready", 64'(M_AXI_BREADY), 64'd1);
    chk("spur_bvalid", 64'(S_BVALID), 64'd0);
    step();
    S_BREADY = 2'b00;
    @(negedge clk);
    chk("spur_bready_nos", 64'(M_AXI_BREADY), 64'd1);
    chk("spur_busy", 64'(busy), 64'd0);
    step();
    M_AXI_BVALID = 1'b0;
    S_BREADY = 2'b11;
    step();

    chk("aw_q_empty", 64'(aw_q.size()), 64'd0);
    chk("g_q_empty", 64'(g_q.size()), 64'd0);
    chk("r_q_empty", 64'(r_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wr_burst_arbiter.md
WR_BURST_ARBITER -- requirements
Module: wr_burst_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of granted bursts awaiting a B response (power of 2, range 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports S_AWADDR/S_AWLEN/S_AWVALID, input, 2x64/2x8/2: per-requester burst command (requester i in slice i).
REQ-005 SHALL have port S_AWREADY, output, 2 bits: per-requester command accept.
REQ-006 SHALL have ports S_WDATA/S_WSTRB/S_WLAST/S_WVALID, input, 2x512/2x64/2/2: per-requester write beats.
REQ-007 SHALL have port S_WREADY, output, 2 bits: per-requester beat accept.
REQ-008 SHALL have ports S_BRESP/S_BVALID, output, 2x2/2, and port S_BREADY, input, 2: per-requester write response.
REQ-009 SHALL have AXI4 master ports M_AXI_AWADDR(64), AWLEN(8), AWVALID, AWREADY, AWSIZE(3), AWBURST(2), WDATA(512), WSTRB(64), WLAST, WVALID, WREADY, BRESP(2), BVALID, BREADY; the usual directions apply.
REQ-010 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE or the grant FIFO is non-empty.

Function
REQ-011 SHALL drive M_AXI_AWSIZE=6 and M_AXI_AWBURST=1 (INCR) at all times.
REQ-012 SHALL use FSM states IDLE, XFER and AWWAIT.
REQ-013 IDLE: when any S_AWVALID is high and the grant FIFO is not full, SHALL grant one requester by round-robin, where the requester not granted last wins a tie.
REQ-014 Grant cycle N: SHALL pulse S_AWREADY[g] for exactly cycle N, register address and length, push g into the grant FIFO, and go to XFER.
REQ-015 SHALL drive M_AXI_AWVALID high from cycle N+1 until the AWREADY handshake.
REQ-016 XFER: SHALL connect M_AXI_W* to requester g combinationally, with S_WREADY[g]=M_AXI_WREADY and S_WREADY of the other requester =0; M_AXI_WVALID SHALL be 0 outside XFER.
REQ-017 On the handshake with WLAST=1: SHALL go to IDLE if AW is already accepted or accepted in the same cycle, else go to AWWAIT.
REQ-018 AWWAIT: on the AW handshake SHALL go to IDLE.
REQ-019 The W stream SHALL NOT be blocked waiting for AW acceptance.
REQ-020 SHALL pass WLAST through from the requester and SHALL NOT check it against AWLEN.
REQ-021 B routing: with the FIFO head h and the FIFO non-empty, SHALL drive S_BVALID[h]=M_AXI_BVALID, S_BRESP[h]=M_AXI_BRESP, M_AXI_BREADY=S_BREADY[h]; the FIFO SHALL pop on the handshake.
REQ-022 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-023 When the FIFO is full, SHALL NOT grant; a pop in the evaluating cycle SHALL NOT enable a grant until the next cycle.
REQ-024 M_AXI_BVALID with an empty FIFO: SHALL drive BREADY=1, discard the response, and hold no S_BVALID high.
REQ-025 S_AWLEN=255 SHALL be forwarded unchanged.
REQ-026 Occupancy SHALL be $clog2(MAX_OUTSTANDING)+1 bits wide.

Reset
REQ-027 Asserting resetn low SHALL immediately force all of: FSM=IDLE, FIFO empty, round-robin favouring requester 0, every VALID/READY output 0, M_AXI_AWADDR=0, M_AXI_AWLEN=0, busy=0.
REQ-028 Assertion mid-burst SHALL abandon the burst, with no completion of the burst and no response delivered.

Configuration
REQ-029 With macro WR_ARB_STATS_EN defined, SHALL add outputs grant_count (2x32, per requester, wrapping) and bresp_err_count (32, counts routed BRESP!=0, saturating at 0xFFFFFFFF), all cleared by reset.
REQ-030 With WR_ARB_STATS_EN undefined, SHALL NOT provide those ports and SHALL NOT instantiate those counters.

Structure
REQ-031 Package wr_arb_pkg SHALL hold the FSM state enum, AXI_SIZE_64B=6, AXI_BURST_INCR=1 and RESP_OKAY/SLVERR/DECERR.
REQ-032 The grant FIFO SHALL be sub-module grant_fifo (width 1, depth MAX_OUTSTANDING, full/empty flags, simultaneous push/pop).

Verification
REQ-033 Both requesters request len=3 at the same cycle after reset -> requester 0 granted first, 4 beats pass, then requester 1 granted; AW addresses appear in that order.
REQ-034 AWREADY held low 10 cycles while requester 0 streams 4 beats with WREADY=1 -> all beats pass, FSM holds in AWWAIT, then IDLE one cycle after the AW handshake.
REQ-035 MAX_OUTSTANDING=4, BVALID withheld, 6 single-beat commands -> exactly 4 granted; the 5th is granted the cycle after the first B pop.
REQ-036 B responses OKAY, SLVERR for grants 0,1 -> S_BVALID[0] sees OKAY, S_BVALID[1] sees SLVERR; with WR_ARB_STATS_EN, bresp_err_count=1.
REQ-037 resetn low mid-burst at beat 2 of 4 -> all valids 0 in the same cycle; busy=0; the next request is granted normally.
REQ-038 Spurious M_AXI_BVALID with FIFO empty -> BREADY=1, no S_BVALID asserted.
